// File: rtl/unidade_controle_jogo_if.sv
// -----------------------------------------------------------------------------
// unidade_controle_jogo_if
//
// Control/status bundle between the game control unit and the game datapath.
//
// Signal groups:
//   control strobes (control unit -> datapath)
//     rst_global          clear the whole datapath
//     zera_CS, inc_seed   seed counter clear / increment
//     e_seed_reg          load the seed register from the seed counter
//     zera_CJ, inc_jogador player counter clear / increment
//     mostra_classe       show the current player's role (held while waiting)
//     processar_acao      apply the current player's night action
//     avaliar_eliminacao  apply the night's elimination
//     voto                register the day vote
//     morra               kill the voted player
//   status flags (datapath -> control unit)
//     CJ_fim              player counter sits on the last player
//     jogador_vivo        current player is alive
//     jogou               last night action was valid
//     votou               last vote was valid
//     acertou             voted player is the wolf
//     sinal_lobo_ganhou   enough deaths for the wolf to win
//
// Handshake semantics: there is no valid/ready pair on this bundle. Every
// strobe is a level decoded from the control unit's state register and is
// sampled by the datapath on the rising clock edge that ends the cycle in
// which it is high; a strobe high for N cycles acts N times. Status flags
// are registered in the datapath and are consumed by the control unit one
// state after the strobe that produced them, so no flag is ever read in the
// same cycle as the strobe that updates it.
// -----------------------------------------------------------------------------
interface unidade_controle_jogo_if;
  // control strobes
  logic rst_global;
  logic zera_CS;
  logic inc_seed;
  logic e_seed_reg;
  logic zera_CJ;
  logic inc_jogador;
  logic mostra_classe;
  logic processar_acao;
  logic avaliar_eliminacao;
  logic voto;
  logic morra;
  // status flags
  logic CJ_fim;
  logic jogador_vivo;
  logic jogou;
  logic votou;
  logic acertou;
  logic sinal_lobo_ganhou;

  modport master (
    output rst_global, zera_CS, inc_seed, e_seed_reg, zera_CJ, inc_jogador,
    output mostra_classe, processar_acao, avaliar_eliminacao, voto, morra,
    input  CJ_fim, jogador_vivo, jogou, votou, acertou, sinal_lobo_ganhou
  );

  modport slave (
    input  rst_global, zera_CS, inc_seed, e_seed_reg, zera_CJ, inc_jogador,
    input  mostra_classe, processar_acao, avaliar_eliminacao, voto, morra,
    output CJ_fim, jogador_vivo, jogou, votou, acertou, sinal_lobo_ganhou
  );
endinterface

// File: rtl/unidade_controle_jogo.sv
// -----------------------------------------------------------------------------
// unidade_controle_jogo
//
// Control unit for one match of the game. Sequences seed selection, the
// night turn of every player, the night elimination, the day vote and the
// win checks, driving all datapath strobes through the dp interface.
//
// Ports:
//   clock         system clock (single domain)
//   rst_global_n  synchronous active-low reset, forces INICIAL from any state
//   iniciar       one-cycle pulse: start a match / restart after the end
//   confirma      one-cycle pulse: the player confirms the current choice
//   dp            master side of the datapath control/status bundle
//   fim_jogo      match over
//   lobo_venceu   meaningful while fim_jogo=1: 1 wolf wins, 0 villagers win
//   db_estado     current state encoding, for debug and checkers
//
// Parameters:
//   TIMEOUT_CICLOS  cycles a player may idle in MOSTRA or VOTO before the
//                   turn (or the day's vote) is skipped
//   TW              timeout counter width, must hold TIMEOUT_CICLOS-1
// -----------------------------------------------------------------------------
module unidade_controle_jogo #(
  parameter int TIMEOUT_CICLOS = 500000000,
  parameter int TW             = 29
) (
  input  logic                       clock,
  input  logic                       rst_global_n,
  input  logic                       iniciar,
  input  logic                       confirma,
  unidade_controle_jogo_if.master    dp,
  output logic                       fim_jogo,
  output logic                       lobo_venceu,
  output logic [4:0]                 db_estado
);

  typedef enum logic [4:0] {
    S_INICIAL       = 5'd0,
    S_ESPERA        = 5'd1,
    S_CARREGA       = 5'd2,
    S_CHECA_VIVO    = 5'd3,
    S_MOSTRA        = 5'd4,
    S_ACAO          = 5'd5,
    S_VERIFICA      = 5'd6,
    S_PROXIMO       = 5'd7,
    S_AVALIA        = 5'd8,
    S_CHECA_NOITE   = 5'd9,
    S_VOTO          = 5'd10,
    S_REGISTRA_VOTO = 5'd11,
    S_VERIFICA_VOTO = 5'd12,
    S_MATA          = 5'd13,
    S_CHECA_DIA     = 5'd14,
    S_NOITE_RETORNO = 5'd15,
    S_FIM_LOBO      = 5'd16,
    S_FIM_ALDEOES   = 5'd17
  } estado_t;

  localparam logic [TW-1:0] TIMEOUT_LIM = TW'(TIMEOUT_CICLOS - 1);

  estado_t       state_q, state_d;
  logic [TW-1:0] timeout_q, timeout_d;
  logic          timeout_hit;

  // strobe values decoded from the state register
  logic rst_global_s;
  logic zera_cs_s;
  logic inc_seed_s;
  logic e_seed_reg_s;
  logic zera_cj_s;
  logic inc_jogador_s;
  logic mostra_classe_s;
  logic processar_acao_s;
  logic avaliar_eliminacao_s;
  logic voto_s;
  logic morra_s;
  logic fim_jogo_s;
  logic lobo_venceu_s;

  assign timeout_hit = (timeout_q == TIMEOUT_LIM);

  // ---------------------------------------------------------------------------
  // State and timeout registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!rst_global_n) begin
      state_q   <= S_INICIAL;
      timeout_q <= '0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Timeout counter: restarts on every state change, so a retry from
  // VERIFICA back to MOSTRA (or VERIFICA_VOTO back to VOTO) gets a fresh
  // budget. It only runs while the FSM is parked waiting for a player.
  // ---------------------------------------------------------------------------
  always_comb begin
    timeout_d = '0;
    if (state_d == state_q && (state_q == S_MOSTRA || state_q == S_VOTO)) begin
      timeout_d = timeout_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d              = state_q;
    rst_global_s         = 1'b0;
    zera_cs_s            = 1'b0;
    inc_seed_s           = 1'b0;
    e_seed_reg_s         = 1'b0;
    zera_cj_s            = 1'b0;
    inc_jogador_s        = 1'b0;
    mostra_classe_s      = 1'b0;
    processar_acao_s     = 1'b0;
    avaliar_eliminacao_s = 1'b0;
    voto_s               = 1'b0;
    morra_s              = 1'b0;
    fim_jogo_s           = 1'b0;
    lobo_venceu_s        = 1'b0;

    case (state_q)
      S_INICIAL: begin
        rst_global_s = 1'b1;
        zera_cs_s    = 1'b1;
        zera_cj_s    = 1'b1;
        state_d      = S_ESPERA;
      end

      // The seed counter free-runs while the players wait to start; the
      // moment of iniciar picks the seed.
      S_ESPERA: begin
        inc_seed_s = 1'b1;
        if (iniciar) state_d = S_CARREGA;
      end

      S_CARREGA: begin
        e_seed_reg_s = 1'b1;
        zera_cj_s    = 1'b1;
        state_d      = S_CHECA_VIVO;
      end

      S_CHECA_VIVO: begin
        state_d = dp.jogador_vivo ? S_MOSTRA : S_PROXIMO;
      end

      // confirma takes priority over an expiring timeout on the same cycle.
      S_MOSTRA: begin
        mostra_classe_s = 1'b1;
        if (confirma)         state_d = S_ACAO;
        else if (timeout_hit) state_d = S_PROXIMO;
      end

      S_ACAO: begin
        processar_acao_s = 1'b1;
        state_d          = S_VERIFICA;
      end

      // jogou is registered by the datapath at the end of ACAO.
      S_VERIFICA: begin
        state_d = dp.jogou ? S_PROXIMO : S_MOSTRA;
      end

      // The increment is suppressed on the last player so the counter still
      // points at a valid slot when the night is evaluated; this strobe is
      // therefore the one output that also looks at a status flag.
      S_PROXIMO: begin
        if (dp.CJ_fim) begin
          state_d = S_AVALIA;
        end else begin
          inc_jogador_s = 1'b1;
          state_d       = S_CHECA_VIVO;
        end
      end

      S_AVALIA: begin
        avaliar_eliminacao_s = 1'b1;
        state_d              = S_CHECA_NOITE;
      end

      S_CHECA_NOITE: begin
        state_d = dp.sinal_lobo_ganhou ? S_FIM_LOBO : S_VOTO;
      end

      // A vote that times out means nobody is eliminated this day.
      S_VOTO: begin
        if (confirma)         state_d = S_REGISTRA_VOTO;
        else if (timeout_hit) state_d = S_NOITE_RETORNO;
      end

      S_REGISTRA_VOTO: begin
        voto_s  = 1'b1;
        state_d = S_VERIFICA_VOTO;
      end

      S_VERIFICA_VOTO: begin
        state_d = dp.votou ? S_MATA : S_VOTO;
      end

      S_MATA: begin
        morra_s = 1'b1;
        state_d = S_CHECA_DIA;
      end

      // Catching the wolf ends the match for the villagers even if the
      // same kill also reached the death limit.
      S_CHECA_DIA: begin
        if (dp.acertou)                state_d = S_FIM_ALDEOES;
        else if (dp.sinal_lobo_ganhou) state_d = S_FIM_LOBO;
        else                           state_d = S_NOITE_RETORNO;
      end

      S_NOITE_RETORNO: begin
        zera_cj_s = 1'b1;
        state_d   = S_CHECA_VIVO;
      end

      S_FIM_LOBO: begin
        fim_jogo_s    = 1'b1;
        lobo_venceu_s = 1'b1;
        if (iniciar) state_d = S_INICIAL;
      end

      S_FIM_ALDEOES: begin
        fim_jogo_s = 1'b1;
        if (iniciar) state_d = S_INICIAL;
      end

      // Unused encodings recover through a full datapath clear.
      default: begin
        state_d = S_INICIAL;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output wiring
  // ---------------------------------------------------------------------------
  assign dp.rst_global         = rst_global_s;
  assign dp.zera_CS            = zera_cs_s;
  assign dp.inc_seed           = inc_seed_s;
  assign dp.e_seed_reg         = e_seed_reg_s;
  assign dp.zera_CJ            = zera_cj_s;
  assign dp.inc_jogador        = inc_jogador_s;
  assign dp.mostra_classe      = mostra_classe_s;
  assign dp.processar_acao     = processar_acao_s;
  assign dp.avaliar_eliminacao = avaliar_eliminacao_s;
  assign dp.voto               = voto_s;
  assign dp.morra              = morra_s;
  assign fim_jogo              = fim_jogo_s;
  assign lobo_venceu           = lobo_venceu_s;
  assign db_estado             = state_q;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// -----------------------------------------------------------------------------
// tb_unidade_controle_jogo
//
// Each table row describes one clock cycle: the inputs driven during the
// cycle, the state the DUT must be in, and the 13 output strobes it must
// show. Rows are applied at the falling edge and checked 1 time unit later;
// the following rising edge then moves the DUT to the next row's state.
// A reactive sequence afterwards plays a complete all-alive night and
// counts strobe pulses.
// -----------------------------------------------------------------------------
module tb_unidade_controle_jogo;

  localparam int TO = 8;

  // state encodings
  localparam logic [4:0] INI = 5'd0,  ESP = 5'd1,  CAR = 5'd2,  CV  = 5'd3;
  localparam logic [4:0] MO  = 5'd4,  AC  = 5'd5,  VE  = 5'd6,  PR  = 5'd7;
  localparam logic [4:0] AV  = 5'd8,  CN  = 5'd9,  VT  = 5'd10, RV  = 5'd11;
  localparam logic [4:0] VV  = 5'd12, MA  = 5'd13, CD  = 5'd14, NR  = 5'd15;
  localparam logic [4:0] FL  = 5'd16, FA  = 5'd17;

  // output vector bits: {rst_global, zera_CS, inc_seed, e_seed_reg, zera_CJ,
  // inc_jogador, mostra_classe, processar_acao, avaliar_eliminacao, voto,
  // morra, fim_jogo, lobo_venceu}
  localparam logic [12:0] B_RSTG = 13'h1000, B_ZCS  = 13'h0800;
  localparam logic [12:0] B_INCS = 13'h0400, B_ESED = 13'h0200;
  localparam logic [12:0] B_ZCJ  = 13'h0100, B_INCJ = 13'h0080;
  localparam logic [12:0] B_MOST = 13'h0040, B_PROC = 13'h0020;
  localparam logic [12:0] B_AVAL = 13'h0010, B_VOTO = 13'h0008;
  localparam logic [12:0] B_MORR = 13'h0004, B_FIM  = 13'h0002;
  localparam logic [12:0] B_LOBO = 13'h0001, O_NONE = 13'h0000;

  localparam logic [12:0] O_INI = B_RSTG | B_ZCS | B_ZCJ;
  localparam logic [12:0] O_CAR = B_ESED | B_ZCJ;
  localparam logic [12:0] O_FL  = B_FIM | B_LOBO;

  // input bits
  localparam logic [8:0] I_NONE = 9'h000, I_INI  = 9'h001, I_CONF = 9'h002;
  localparam logic [8:0] I_CJ   = 9'h004, I_VIVO = 9'h008, I_JOG  = 9'h010;
  localparam logic [8:0] I_VOT  = 9'h020, I_ACE  = 9'h040, I_LOBO = 9'h080;
  localparam logic [8:0] I_RST  = 9'h100;

  typedef struct {
    logic [8:0]  ins;
    logic [4:0]  st;
    logic [12:0] outs;
  } vec_t;

  // ---------------------------------------------------------------------------
  // clock / reset
  // ---------------------------------------------------------------------------
  logic clock = 1'b0;
  logic rst_global_n;
  logic iniciar;
  logic confirma;
  logic fim_jogo;
  logic lobo_venceu;
  logic [4:0] db_estado;
  logic [12:0] outs;

  always #5 clock = ~clock;

  unidade_controle_jogo_if dp_if ();

  unidade_controle_jogo #(
    .TIMEOUT_CICLOS(TO),
    .TW(4)
  ) dut (
    .clock(clock),
    .rst_global_n(rst_global_n),
    .iniciar(iniciar),
    .confirma(confirma),
    .dp(dp_if),
    .fim_jogo(fim_jogo),
    .lobo_venceu(lobo_venceu),
    .db_estado(db_estado)
  );

  assign outs = {dp_if.rst_global, dp_if.zera_CS, dp_if.inc_seed,
                 dp_if.e_seed_reg, dp_if.zera_CJ, dp_if.inc_jogador,
                 dp_if.mostra_classe, dp_if.processar_acao,
                 dp_if.avaliar_eliminacao, dp_if.voto, dp_if.morra,
                 fim_jogo, lobo_venceu};

  // ---------------------------------------------------------------------------
  // scoreboard
  // ---------------------------------------------------------------------------
  int n_pass  = 0;
  int n_total = 0;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void row(input logic [4:0] st, input logic [12:0] o,
                              input logic [8:0] in);
    vec_t v;
    v.ins  = in;
    v.st   = st;
    v.outs = o;
    vecs.push_back(v);
  endfunction

  // ---------------------------------------------------------------------------
  // driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [8:0] in);
    iniciar                 = in[0];
    confirma                = in[1];
    dp_if.CJ_fim            = in[2];
    dp_if.jogador_vivo      = in[3];
    dp_if.jogou             = in[4];
    dp_if.votou             = in[5];
    dp_if.acertou           = in[6];
    dp_if.sinal_lobo_ganhou = in[7];
    rst_global_n            = ~in[8];
  endtask

  // one player's normal turn: alive, confirms, valid action
  task automatic turn_ok(input logic [8:0] cj);
    row(CV, O_NONE, I_VIVO | cj);
    row(MO, B_MOST, I_CONF | cj);
    row(AC, B_PROC, cj);
    row(VE, O_NONE, I_JOG | cj);
  endtask

  // fast path from a reloaded match straight to the day vote
  task automatic skip_to_vote();
    row(CV, O_NONE, I_CJ);
    row(PR, O_NONE, I_CJ);
    row(AV, B_AVAL, I_NONE);
    row(CN, O_NONE, I_NONE);
    row(VT, O_NONE, I_CONF);
    row(RV, B_VOTO, I_NONE);
    row(VV, O_NONE, I_VOT);
  endtask

  initial begin
    int p;
    int n_proc, n_incj, n_aval, n_most, n_morra, n_seed;
    bit reached;

    // ---- vector table ----
    // start: 7 cycles in ESPERA, iniciar on the 7th
    row(INI, O_INI, I_NONE);
    for (int i = 0; i < 6; i++) row(ESP, B_INCS, I_NONE);
    row(ESP, B_INCS, I_INI);
    row(CAR, O_CAR, I_NONE);
    // player 0, confirma in VERIFICA must be ignored
    row(CV, O_NONE, I_VIVO);
    row(MO, B_MOST, I_CONF);
    row(AC, B_PROC, I_NONE);
    row(VE, O_NONE, I_JOG | I_CONF);
    row(PR, B_INCJ, I_NONE);
    // player 1
    turn_ok(I_NONE);
    row(PR, B_INCJ, I_NONE);
    // player 2 dead: no MOSTRA/ACAO, increment still issued
    row(CV, O_NONE, I_NONE);
    row(PR, B_INCJ, I_NONE);
    // player 3: invalid target, then retry
    row(CV, O_NONE, I_VIVO);
    row(MO, B_MOST, I_CONF);
    row(AC, B_PROC, I_NONE);
    row(VE, O_NONE, I_NONE);
    row(MO, B_MOST, I_CONF);
    row(AC, B_PROC, I_NONE);
    row(VE, O_NONE, I_JOG);
    row(PR, B_INCJ, I_NONE);
    // player 4 (last): no increment
    turn_ok(I_CJ);
    row(PR, O_NONE, I_CJ);
    row(AV, B_AVAL, I_NONE);
    row(CN, O_NONE, I_NONE);
    // vote: dead target, retry, valid, not the wolf
    row(VT, O_NONE, I_CONF);
    row(RV, B_VOTO, I_NONE);
    row(VV, O_NONE, I_NONE);
    row(VT, O_NONE, I_CONF);
    row(RV, B_VOTO, I_NONE);
    row(VV, O_NONE, I_VOT);
    row(MA, B_MORR, I_NONE);
    row(CD, O_NONE, I_NONE);
    row(NR, B_ZCJ, I_NONE);
    // MOSTRA timeout: 8 idle cycles, then PROXIMO with no action
    row(CV, O_NONE, I_VIVO);
    for (int i = 0; i < TO; i++) row(MO, B_MOST, I_NONE);
    row(PR, B_INCJ, I_NONE);
    // confirma on the very cycle the timeout expires wins
    row(CV, O_NONE, I_VIVO | I_CJ);
    for (int i = 0; i < TO - 1; i++) row(MO, B_MOST, I_CJ);
    row(MO, B_MOST, I_CONF | I_CJ);
    row(AC, B_PROC, I_CJ);
    row(VE, O_NONE, I_JOG | I_CJ);
    row(PR, O_NONE, I_CJ);
    row(AV, B_AVAL, I_NONE);
    row(CN, O_NONE, I_NONE);
    // VOTO timeout: no vote, no kill
    for (int i = 0; i < TO; i++) row(VT, O_NONE, I_NONE);
    row(NR, B_ZCJ, I_NONE);
    // reset while in MATA
    skip_to_vote();
    row(MA, B_MORR, I_RST);
    row(INI, O_INI, I_NONE);
    row(ESP, B_INCS, I_INI);
    row(CAR, O_CAR, I_NONE);
    // wolf wins at night; end state holds and ignores confirma
    row(CV, O_NONE, I_CJ);
    row(PR, O_NONE, I_CJ);
    row(AV, B_AVAL, I_NONE);
    row(CN, O_NONE, I_LOBO);
    row(FL, O_FL, I_CONF);
    row(FL, O_FL, I_NONE);
    row(FL, O_FL, I_INI);
    row(INI, O_INI, I_NONE);
    row(ESP, B_INCS, I_INI);
    row(CAR, O_CAR, I_NONE);
    // villagers win: acertou has priority over sinal_lobo_ganhou
    skip_to_vote();
    row(MA, B_MORR, I_NONE);
    row(CD, O_NONE, I_ACE | I_LOBO);
    row(FA, B_FIM, I_NONE);
    row(FA, B_FIM, I_INI);
    row(INI, O_INI, I_NONE);
    row(ESP, B_INCS, I_INI);
    row(CAR, O_CAR, I_NONE);
    // wolf wins by the day kill
    skip_to_vote();
    row(MA, B_MORR, I_NONE);
    row(CD, O_NONE, I_LOBO);
    row(FL, O_FL, I_INI);

    // ---- reset ----
    drive(I_RST);
    repeat (3) @(posedge clock);

    // ---- table application ----
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      drive(vecs[i].ins);
      #1;
      check($sformatf("row%0d_state", i), 32'(db_estado), 32'(vecs[i].st));
      check($sformatf("row%0d_outs", i), 32'(outs), 32'(vecs[i].outs));
    end

    // ---- reactive full night, all alive, all actions valid ----
    p = 0;
    n_proc = 0; n_incj = 0; n_aval = 0; n_most = 0; n_morra = 0; n_seed = 0;
    reached = 1'b0;
    for (int cyc = 0; cyc < 300 && !reached; cyc++) begin
      @(negedge clock);
      if (db_estado == VT) begin
        reached = 1'b1;
      end else begin
        iniciar                 = (db_estado == ESP);
        confirma                = (db_estado == MO);
        dp_if.CJ_fim            = (p == 4);
        dp_if.jogador_vivo      = 1'b1;
        dp_if.jogou             = 1'b1;
        dp_if.votou             = 1'b0;
        dp_if.acertou           = 1'b0;
        dp_if.sinal_lobo_ganhou = 1'b0;
        rst_global_n            = 1'b1;
        #1;
        n_proc  += int'(dp_if.processar_acao);
        n_incj  += int'(dp_if.inc_jogador);
        n_aval  += int'(dp_if.avaliar_eliminacao);
        n_most  += int'(dp_if.mostra_classe);
        n_morra += int'(dp_if.morra);
        n_seed  += int'(dp_if.inc_seed);
        if (dp_if.zera_CJ)          p = 0;
        else if (dp_if.inc_jogador) p++;
      end
    end
    check("night_reaches_voto", 32'(reached), 32'd1);
    check("night_proc_pulses", 32'(n_proc), 32'd5);
    check("night_incj_pulses", 32'(n_incj), 32'd4);
    check("night_aval_pulses", 32'(n_aval), 32'd1);
    check("night_mostra_cycles", 32'(n_most), 32'd5);
    check("night_morra_pulses", 32'(n_morra), 32'd0);
    check("night_seed_pulses", 32'(n_seed), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
